// File: rtl/microseq_control_store.sv
// microseq_control_store
//   Writable microstore plus microsequencer for the multicycle CPU control
//   unit. Each cycle the microword of the active state selects the next
//   state (restart, increment, jump, conditional branch, opcode dispatch,
//   wait, call, return). The next state and its control word are registered
//   onto the outputs. A load port fills the microstore and the opcode
//   dispatch table while the sequencer is held.
//
//   Microword layout, LSB first:
//   ctrl[CTRL_W] | mode[3] | csel[CSEL_W] | cinv[1] | target[STATE_W]
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous, active-high; clears both memories
//   stall         hold state, outputs and return register
//   cond          condition flags from the datapath
//   opcode        dispatch-table index
//   wr_en         load-port strobe (also holds the sequencer)
//   wr_sel        0 = microstore, 1 = dispatch table
//   wr_addr       load-port address
//   wr_data       load-port data (full microword)
//   ctrl_signals  registered control word of the active state
//   active_state  registered current state
//   seq_err       one-cycle pulse on a sequencing error
//
// mode | meaning
// 000  | RESTART  : go to RESET_STATE
// 001  | INC      : go to S+1
// 010  | JUMP     : go to target
// 011  | COND     : c ? target : S+1
// 100  | DISPATCH : go to dtab[opcode]
// 101  | WAIT     : c ? S+1 : S
// 110  | CALL     : save S+1, go to target
// 111  | RETURN   : go to saved address, error if none saved

module microseq_control_store #(
  parameter int STATE_W = 7,
  parameter int DEPTH = 128,
  parameter int CTRL_W = 44,
  parameter int OPC_W = 6,
  parameter int NCOND = 4,
  parameter int RESET_STATE = 0,
  // Legacy 56-bit reset word, truncated to its low CTRL_W bits.
  parameter logic [CTRL_W-1:0] RESET_CTRL = 44'h00001008001,
  localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int MW_W = CTRL_W + 3 + CSEL_W + 1 + STATE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [NCOND-1:0]   cond,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [STATE_W-1:0] wr_addr,
  input  logic [MW_W-1:0]    wr_data,
  output logic [CTRL_W-1:0]  ctrl_signals,
  output logic [STATE_W-1:0] active_state,
  output logic               seq_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MODE_LSB = CTRL_W;
  localparam int CSEL_LSB = CTRL_W + 3;
  localparam int CINV_BIT = CSEL_LSB + CSEL_W;
  localparam int TGT_LSB = CINV_BIT + 1;

  localparam logic [STATE_W:0] DEPTH_W = DEPTH[STATE_W:0];
  localparam logic [STATE_W-1:0] RST_S = RESET_STATE[STATE_W-1:0];
  localparam logic [STATE_W:0] ONE_W = {{STATE_W{1'b0}}, 1'b1};

  localparam logic [2:0] M_RESTART = 3'b000;
  localparam logic [2:0] M_INC = 3'b001;
  localparam logic [2:0] M_JUMP = 3'b010;
  localparam logic [2:0] M_COND = 3'b011;
  localparam logic [2:0] M_DISPATCH = 3'b100;
  localparam logic [2:0] M_WAIT = 3'b101;
  localparam logic [2:0] M_CALL = 3'b110;
  localparam logic [2:0] M_RETURN = 3'b111;

  logic [MW_W-1:0]    mem [DEPTH];
  logic [STATE_W-1:0] dtab [2**OPC_W];

  // Return address kept one bit wider so a CALL from the last state
  // returns to an out-of-range address and is flagged then.
  logic [STATE_W:0]   ret;
  logic               ret_v;

  logic [2:0]         mode;
  logic [CSEL_W-1:0]  csel;
  logic               cinv;
  logic [STATE_W-1:0] target;
  logic               c_flag;
  logic [STATE_W:0]   s_inc;
  logic [STATE_W:0]   nxt_raw;
  logic [STATE_W-1:0] nxt_state;
  logic               nxt_err;
  logic               ret_load;
  logic               ret_clear;
  logic               hold;

  // active_state is always below DEPTH, so the low AW bits index safely.
  always_comb begin
    mode = mem[active_state[AW-1:0]][MODE_LSB +: 3];
    csel = mem[active_state[AW-1:0]][CSEL_LSB +: CSEL_W];
    cinv = mem[active_state[AW-1:0]][CINV_BIT];
    target = mem[active_state[AW-1:0]][TGT_LSB +: STATE_W];
    c_flag = cond[csel] ^ cinv;
    s_inc = {1'b0, active_state} + ONE_W;
    nxt_raw = {1'b0, RST_S};
    nxt_err = 1'b0;
    ret_load = 1'b0;
    ret_clear = 1'b0;
    case (mode)
      M_RESTART:  nxt_raw = {1'b0, RST_S};
      M_INC:      nxt_raw = s_inc;
      M_JUMP:     nxt_raw = {1'b0, target};
      M_COND:     nxt_raw = c_flag ? {1'b0, target} : s_inc;
      M_DISPATCH: nxt_raw = {1'b0, dtab[opcode]};
      M_WAIT:     nxt_raw = c_flag ? s_inc : {1'b0, active_state};
      M_CALL: begin
        ret_load = 1'b1;
        nxt_raw = {1'b0, target};
      end
      M_RETURN: begin
        if (ret_v) begin
          ret_clear = 1'b1;
          nxt_raw = ret;
        end else begin
          nxt_err = 1'b1;
          nxt_raw = {1'b0, RST_S};
        end
      end
      default:    nxt_raw = {1'b0, RST_S};
    endcase
    if (nxt_raw >= DEPTH_W) begin
      nxt_state = RST_S;
      nxt_err = 1'b1;
    end else begin
      nxt_state = nxt_raw[STATE_W-1:0];
    end
  end

  // A load-port write holds the sequencer, so a memory is never written
  // and read for the next control word in the same cycle.
  assign hold = stall | wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_state <= RST_S;
      ctrl_signals <= RESET_CTRL;
      seq_err <= 1'b0;
      ret <= '0;
      ret_v <= 1'b0;
    end else if (hold) begin
      seq_err <= 1'b0;
    end else begin
      active_state <= nxt_state;
      ctrl_signals <= mem[nxt_state[AW-1:0]][CTRL_W-1:0];
      seq_err <= nxt_err;
      if (ret_load) begin
        ret <= s_inc;
        ret_v <= 1'b1;
      end else if (ret_clear) begin
        ret_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int j = 0; j < 2**OPC_W; j++) dtab[j] <= RST_S;
    end else if (wr_en) begin
      if (wr_sel) begin
        dtab[wr_addr[OPC_W-1:0]] <= wr_data[STATE_W-1:0];
      end else if ({1'b0, wr_addr} < DEPTH_W) begin
        mem[wr_addr[AW-1:0]] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_microseq_control_store.sv
// Bench for microseq_control_store: each stimulus cycle pushes the expected
// outputs to a scoreboard queue; a monitor pops and compares them just after
// the next rising edge.
module tb_microseq_control_store;

  localparam int STATE_W = 7;
  localparam int DEPTH = 24;
  localparam int CTRL_W = 44;
  localparam int OPC_W = 6;
  localparam int NCOND = 4;
  localparam int MW_W = CTRL_W + 3 + 2 + 1 + STATE_W;
  localparam logic [CTRL_W-1:0] RST_CTRL = 44'h00001008001;

  localparam logic [2:0] M_RESTART = 3'b000;
  localparam logic [2:0] M_INC = 3'b001;
  localparam logic [2:0] M_JUMP = 3'b010;
  localparam logic [2:0] M_COND = 3'b011;
  localparam logic [2:0] M_DISPATCH = 3'b100;
  localparam logic [2:0] M_WAIT = 3'b101;
  localparam logic [2:0] M_CALL = 3'b110;
  localparam logic [2:0] M_RETURN = 3'b111;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic [NCOND-1:0]   cond;
  logic [OPC_W-1:0]   opcode;
  logic               wr_en;
  logic               wr_sel;
  logic [STATE_W-1:0] wr_addr;
  logic [MW_W-1:0]    wr_data;
  logic [CTRL_W-1:0]  ctrl_signals;
  logic [STATE_W-1:0] active_state;
  logic               seq_err;

  typedef struct {
    logic [STATE_W-1:0] s;
    logic [CTRL_W-1:0]  c;
    logic               e;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  microseq_control_store #(
    .STATE_W(STATE_W), .DEPTH(DEPTH), .CTRL_W(CTRL_W),
    .OPC_W(OPC_W), .NCOND(NCOND), .RESET_STATE(0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .cond(cond), .opcode(opcode),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .ctrl_signals(ctrl_signals), .active_state(active_state), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [MW_W-1:0] mw(input logic [2:0] mode, input logic [6:0] tgt,
                                          input logic [CTRL_W-1:0] ctrl);
    // csel fixed at 2, cinv 0: every conditional in this program tests cond[2].
    return {tgt, 1'b0, 2'd2, mode, ctrl};
  endfunction

  // Called at a falling edge with inputs already set; expectation is for
  // the outputs after the next rising edge.
  task automatic step(input int s, input logic [CTRL_W-1:0] c, input bit e);
    exp_t x;
    x.s = s[STATE_W-1:0];
    x.c = c;
    x.e = e;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic load(input bit sel, input int addr, input logic [MW_W-1:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = addr[STATE_W-1:0];
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        check_val("active_state", 64'(active_state), 64'(x.s));
        check_val("ctrl_signals", 64'(ctrl_signals), 64'(x.c));
        check_val("seq_err", 64'(seq_err), 64'(x.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b1; cond = '0; opcode = 6'h23;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    step(0, RST_CTRL, 0);
    reset = 1'b0;
    step(0, RST_CTRL, 0);

    load(0, 0, mw(M_INC, 0, 1));
    load(0, 1, mw(M_JUMP, 0, 2));
    load(0, 2, mw(M_DISPATCH, 0, 7));
    load(0, 3, mw(M_COND, 9, 3));
    load(0, 4, mw(M_JUMP, 5, 4));
    load(0, 5, mw(M_WAIT, 0, 5));
    load(0, 6, mw(M_JUMP, 2, 6));
    load(0, 7, mw(M_CALL, 20, 11));
    load(0, 8, mw(M_RETURN, 0, 13));
    load(0, 9, mw(M_JUMP, 3, 9));
    load(0, 10, mw(M_JUMP, 7, 10));
    load(0, 20, mw(M_RETURN, 0, 12));
    load(1, 'h23, MW_W'(10));
    stall = 1'b0;

    // INC / JUMP loop
    step(1, 2, 0); step(0, 1, 0); step(1, 2, 0); step(0, 1, 0);

    // a load-port write holds the outputs
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd1; wr_data = mw(M_JUMP, 3, 2);
    step(0, 1, 0);
    wr_en = 1'b0;

    // COND taken / not taken, WAIT hold then release
    step(1, 2, 0); step(3, 3, 0);
    cond = 4'b0100; step(9, 9, 0);
    cond = 4'b0000; step(3, 3, 0); step(4, 4, 0); step(5, 5, 0);
    step(5, 5, 0); step(5, 5, 0); step(5, 5, 0);
    cond = 4'b0100; step(6, 6, 0);
    cond = 4'b0000;

    // DISPATCH, CALL/RETURN, RETURN with nothing saved
    step(2, 7, 0); step(10, 10, 0); step(7, 11, 0); step(20, 12, 0);
    step(8, 13, 0); step(0, 1, 1); step(1, 2, 0);

    // stall freezes everything, conditions ignored
    stall = 1'b1; cond = 4'b1111;
    for (int i = 0; i < 4; i++) step(1, 2, 0);
    stall = 1'b0; cond = 4'b0000;
    step(3, 3, 0); step(4, 4, 0); step(5, 5, 0);

    // INC past the last state; out-of-range write dropped silently
    load(0, 6, mw(M_JUMP, 23, 6));
    load(0, 23, mw(M_INC, 0, 23));
    load(0, 100, mw(M_JUMP, 1, 99));
    cond = 4'b0100; step(6, 6, 0);
    cond = 4'b0000; step(23, 23, 0); step(0, 1, 1); step(1, 2, 0);

    // JUMP to a target beyond DEPTH
    load(0, 3, mw(M_JUMP, 30, 3));
    step(3, 3, 0); step(0, 1, 1); step(1, 2, 0);

    // reset during a WAIT loop with writes pending
    load(0, 3, mw(M_JUMP, 5, 3));
    step(3, 3, 0); step(5, 5, 0); step(5, 5, 0);
    reset = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd0; wr_data = mw(M_INC, 0, 77);
    step(0, RST_CTRL, 0);
    wr_sel = 1'b1; wr_addr = 7'h23; wr_data = MW_W'(10);
    step(0, RST_CTRL, 0);
    reset = 1'b0; wr_en = 1'b0; stall = 1'b1;
    step(0, RST_CTRL, 0);
    stall = 1'b0;
    step(0, 0, 0); step(0, 0, 0);

    // dispatch table was cleared to RESET_STATE
    load(0, 0, mw(M_DISPATCH, 0, 5));
    step(0, 5, 0); step(0, 5, 0);

    @(negedge clk);
    @(negedge clk);
    check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
